// File: rtl/latch_stim_checker.sv
// Stimulus driver and checker for an enable-gated, 4-state-sensitive latch.
// Optional build macro: LATCH_CHK_STOP_ON_FAIL_EN ends the run at the first failing step.
module latch_stim_checker #(
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       enb_out,
  input  logic       q_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_step,
  output logic [2:0] err_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_STEP   = 3'd5;
  localparam logic [2:0] NO_FAIL     = 3'd7;
  localparam logic [2:0] ERR_MAX     = 3'd6;
  localparam logic [7:0] SETTLE_LOAD = 8'(STEP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] settle_q, settle_d;
  logic       a_q, a_d;
  logic       enb_q, enb_d;
  logic [2:0] err_q, err_d;
  logic [2:0] fail_q, fail_d;
  logic       miss;

  // Stimulus table: data and enable per step, plus the latch response it must produce.
  function automatic logic step_a(input logic [2:0] k);
    case (k)
      3'd0:    step_a = 1'bx;
      3'd1:    step_a = 1'b0;
      3'd2:    step_a = 1'b1;
      3'd3:    step_a = 1'bz;
      3'd4:    step_a = 1'bx;
      default: step_a = 1'bz;
    endcase
  endfunction

  function automatic logic step_enb(input logic [2:0] k);
    step_enb = (k == LAST_STEP);
  endfunction

  function automatic logic step_exp(input logic [2:0] k);
    step_exp = (k == 3'd1) || (k == 3'd2) || (k == 3'd3);
  endfunction

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= 3'd0;
      settle_q <= 8'd0;
      a_q      <= 1'bx;
      enb_q    <= 1'b0;
      err_q    <= 3'd0;
      fail_q   <= NO_FAIL;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      enb_q    <= enb_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  // NOTE: every _d signal defaults to its _q value first, so no path through this block infers a latch.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    a_d      = a_q;
    enb_d    = enb_q;
    err_d    = err_q;
    fail_d   = fail_q;
    miss     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_DRIVE;
          step_d  = 3'd0;
          err_d   = 3'd0;
          fail_d  = NO_FAIL;
        end
      end
      S_DRIVE: begin
        a_d      = step_a(step_q);
        enb_d    = step_enb(step_q);
        settle_d = SETTLE_LOAD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 8'd0) state_d = S_CHECK;
        else                  settle_d = settle_q - 8'd1;
      end
      S_CHECK: begin
        // Case-inequality: x or z on q_in never matches a 0/1 expectation.
        miss = (q_in !== step_exp(step_q));
        if (miss) begin
          if (err_q != ERR_MAX) err_d = err_q + 3'd1;
          if (fail_q == NO_FAIL) fail_d = step_q;
        end
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRIVE;
          step_d  = step_q + 3'd1;
        end
`ifdef LATCH_CHK_STOP_ON_FAIL_EN
        if (miss) begin
          state_d = S_DONE;
          step_d  = step_q;
        end
`else
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    done      = (state_q == S_DONE);
    pass      = (state_q == S_DONE) && (err_q == 3'd0);
    a_out     = a_q;
    enb_out   = enb_q;
    fail_step = fail_q;
    err_count = err_q;
  end

endmodule

// File: tb/tb_latch_stim_checker.sv
// Directed bench for latch_stim_checker: a per-step latch response table with injectable faults.
// Expectations follow LATCH_CHK_STOP_ON_FAIL_EN when the bench is built with the same macro.
module tb_latch_stim_checker;

  localparam int SC = 2;
`ifdef LATCH_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       q_drv;
  logic       a_out, enb_out, busy, done, pass;
  logic [2:0] fail_step, err_count;

  int total = 0;
  int bad   = 0;

  // Hand-derived correct latch output for each step.
  bit golden [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  bit flt    [6];

  latch_stim_checker #(.STEP_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_out     (a_out),
    .enb_out   (enb_out),
    .q_in      (q_drv),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_step (fail_step),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 6; i++) flt[i] = 1'b0;
  endtask

  // Start sampled at the next rising edge (E0); returns just after E0.
  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Walks the run step by step from just after E0; a faulty step stops early when STOP is set.
  task automatic run(input int nsteps, input int poke_step);
    for (int k = 0; k < nsteps; k++) begin
      q_drv = golden[k] ^ flt[k];
      if (k == poke_step) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check($sformatf("enb_s%0d", k), {7'd0, enb_out}, (k == 5) ? 8'd1 : 8'd0);
      if (k == 1) check("a_s1", {7'd0, a_out}, 8'd0);
      if (k == 2) check("a_s2", {7'd0, a_out}, 8'd1);
      repeat (SC) @(posedge clk);
      #1;
      check($sformatf("busy_pre_s%0d", k), {6'd0, busy, done}, 8'b10);
      @(posedge clk);
      #1;
      if (STOP && flt[k]) break;
    end
  endtask

  task automatic check_result(input string tag, input bit exp_pass,
                              input logic [2:0] exp_fail, input logic [2:0] exp_err);
    check({tag, "_done"}, {6'd0, busy, done}, 8'b01);
    check({tag, "_pass"}, {7'd0, pass}, {7'd0, exp_pass});
    check({tag, "_fail_step"}, {5'd0, fail_step}, {5'd0, exp_fail});
    check({tag, "_err"}, {5'd0, err_count}, {5'd0, exp_err});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    q_drv = 1'b0;
    clear_faults();
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {7'd0, a_out}, {7'd0, 1'bx});
    check("rst_enb", {7'd0, enb_out}, 8'd0);
    check("rst_busy_done_pass", {5'd0, busy, done, pass}, 8'd0);
    check("rst_fail_step", {5'd0, fail_step}, 8'd7);
    check("rst_err", {5'd0, err_count}, 8'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("idle_no_start", {6'd0, busy, done}, 8'd0);

    // Golden run: done exactly 24 edges after start.
    kick();
    check("t1_busy_at_e0", {6'd0, busy, done}, 8'b10);
    run(6, -1);
    check_result("t1", 1'b1, 3'd7, 3'd0);
    check("t1_enb_held", {7'd0, enb_out}, 8'd1);
    repeat (3) @(posedge clk);
    #1 check("t1_done_holds", {6'd0, busy, done, pass}, 8'b011);

    // Wrong response on step 0.
    flt[0] = 1'b1;
    kick();
    run(6, -1);
    check_result("t2", 1'b0, 3'd0, 3'd1);

    // Latch that ignores enb: step 5 mismatches. Restart must clear the previous result.
    clear_faults();
    flt[5] = 1'b1;
    kick();
    check("t3_restart_clear", {busy, done, fail_step, err_count}, {2'b10, 3'd7, 3'd0});
    run(6, -1);
    check_result("t3", 1'b0, 3'd5, 3'd1);

    // Step 1 and step 5 faults: stop-on-fail ends after step 1 (E0+8).
    flt[1] = 1'b1;
    kick();
    run(6, -1);
    check_result("t4", 1'b0, 3'd1, STOP ? 3'd1 : 3'd2);

    // Start pulsed during step 2 is ignored; done still at E0+24.
    clear_faults();
    kick();
    run(6, 2);
    check_result("t6", 1'b1, 3'd7, 3'd0);

    // Reset during step 3 SETTLE, then a clean run.
    kick();
    run(3, -1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_a", {7'd0, a_out}, {7'd0, 1'bx});
    check("t5_rst_enb", {7'd0, enb_out}, 8'd0);
    check("t5_rst_busy_done", {6'd0, busy, done}, 8'd0);
    check("t5_rst_fail_err", {2'd0, fail_step, err_count}, {2'd0, 3'd7, 3'd0});
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("t5_idle_after_rst", {6'd0, busy, done}, 8'd0);
    kick();
    run(6, -1);
    check_result("t5", 1'b1, 3'd7, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
